// File: rtl/control_unit_if.sv
// Control bundle between the sequencer and the single-bus datapath:
// instruction/handshake inputs plus every enable, select and strobe.
interface control_unit_if;
    logic [31:0] ir;
    logic        mem_ack;
    logic        stop;

    logic        PCout, MARin, IncPc, Zin, Zlowout, Zhighout, PCin;
    logic        MDRin, MDRout, IRin, Yin, HIin, LOin, Cout;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        Read, Write;
    logic [3:0]  alu_op;
    logic        run, fault, illegal_op;

    modport master (
        input  ir, mem_ack, stop,
        output PCout, MARin, IncPc, Zin, Zlowout, Zhighout, PCin,
               MDRin, MDRout, IRin, Yin, HIin, LOin, Cout,
               Gra, Grb, Grc, Rin, Rout, BAout,
               Read, Write, alu_op, run, fault, illegal_op
    );

    modport slave (
        output ir, mem_ack, stop,
        input  PCout, MARin, IncPc, Zin, Zlowout, Zhighout, PCin,
               MDRin, MDRout, IRin, Yin, HIin, LOin, Cout,
               Gra, Grb, Grc, Rin, Rout, BAout,
               Read, Write, alu_op, run, fault, illegal_op
    );
endinterface

// File: rtl/control_unit.sv
// Moore T-state sequencer for the 32-bit single-bus datapath: one micro-step
// per clock, outputs decoded from the state register and the opcode only.
module control_unit #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    control_unit_if.master bus
);
    localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
    } state_t;

    typedef enum logic [3:0] {
        K_ALU, K_IMM, K_UNARY, K_MULDIV, K_LDI, K_LD, K_ST, K_NOP, K_HALT, K_ILLEGAL
    } kind_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_MUL = 4'd2, ALU_DIV = 4'd3,
        ALU_SHR = 4'd4, ALU_SHL = 4'd5, ALU_ROR = 4'd6, ALU_ROL = 4'd7,
        ALU_AND = 4'd8, ALU_OR  = 4'd9, ALU_NEG = 4'd10, ALU_NOT = 4'd11
    } alu_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    kind_t         kind;
    alu_t          op_alu;
    logic          mem_wait;
    state_t        t0_or_halt;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        kind   = K_ILLEGAL;
        op_alu = ALU_ADD;
        case (bus.ir[31:27])
            5'b00000: kind = K_LD;
            5'b00001: kind = K_LDI;
            5'b00010: kind = K_ST;
            5'b00011: begin kind = K_ALU;    op_alu = ALU_ADD; end
            5'b00100: begin kind = K_ALU;    op_alu = ALU_SUB; end
            5'b00101: begin kind = K_ALU;    op_alu = ALU_AND; end
            5'b00110: begin kind = K_ALU;    op_alu = ALU_OR;  end
            5'b00111: begin kind = K_ALU;    op_alu = ALU_SHR; end
            5'b01000: begin kind = K_ALU;    op_alu = ALU_SHL; end
            5'b01001: begin kind = K_ALU;    op_alu = ALU_ROR; end
            5'b01010: begin kind = K_ALU;    op_alu = ALU_ROL; end
            5'b01011: begin kind = K_IMM;    op_alu = ALU_ADD; end
            5'b01100: begin kind = K_IMM;    op_alu = ALU_AND; end
            5'b01101: begin kind = K_IMM;    op_alu = ALU_OR;  end
            5'b01110: begin kind = K_MULDIV; op_alu = ALU_MUL; end
            5'b01111: begin kind = K_MULDIV; op_alu = ALU_DIV; end
            5'b10000: begin kind = K_UNARY;  op_alu = ALU_NEG; end
            5'b10001: begin kind = K_UNARY;  op_alu = ALU_NOT; end
            5'b11000: kind = K_NOP;
            5'b11001: kind = K_HALT;
            default:  kind = K_ILLEGAL;
        endcase
    end

    // States that stall on the memory handshake.
    assign mem_wait   = (state == S_T1) ||
                        (state == S_T6 && kind == K_LD) ||
                        (state == S_T7 && kind == K_ST);
    assign t0_or_halt = bus.stop ? S_HALT : S_T0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state    <= S_RST;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            if (mem_wait && !bus.mem_ack) begin
                if (wait_cnt == CW'(MEM_TIMEOUT))
                    state <= S_FAULT;
                else
                    wait_cnt <= wait_cnt + 1'b1;
            end else begin
                case (state)
                    S_RST: state <= t0_or_halt;
                    S_T0:  state <= S_T1;
                    S_T1:  state <= S_T2;
                    S_T2: begin
                        if (kind == K_NOP)       state <= t0_or_halt;
                        else if (kind == K_HALT) state <= S_HALT;
                        else                     state <= S_T3;
                    end
                    S_T3:  state <= (kind == K_ILLEGAL) ? t0_or_halt : S_T4;
                    S_T4:  state <= (kind == K_UNARY) ? t0_or_halt : S_T5;
                    S_T5: begin
                        if (kind == K_ALU || kind == K_IMM || kind == K_LDI)
                            state <= t0_or_halt;
                        else
                            state <= S_T6;
                    end
                    S_T6:    state <= (kind == K_MULDIV) ? t0_or_halt : S_T7;
                    S_T7:    state <= t0_or_halt;
                    S_HALT:  state <= S_HALT;
                    S_FAULT: state <= S_FAULT;
                    default: state <= S_RST;
                endcase
            end
        end
    end

    always_comb begin
        bus.PCout = 1'b0; bus.MARin = 1'b0; bus.IncPc = 1'b0; bus.Zin = 1'b0;
        bus.Zlowout = 1'b0; bus.Zhighout = 1'b0; bus.PCin = 1'b0;
        bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
        bus.HIin = 1'b0; bus.LOin = 1'b0; bus.Cout = 1'b0;
        bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
        bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
        bus.Read = 1'b0; bus.Write = 1'b0;
        bus.alu_op = ALU_ADD;
        bus.illegal_op = 1'b0;
        bus.run   = (state != S_RST) && (state != S_HALT) && (state != S_FAULT);
        bus.fault = (state == S_FAULT);
        case (state)
            S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPc = 1'b1; bus.Zin = 1'b1; end
            S_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
            S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            S_T3: begin
                case (kind)
                    K_ALU, K_IMM: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    K_UNARY: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.alu_op = op_alu; bus.Zin = 1'b1;
                    end
                    K_MULDIV: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    K_LDI, K_LD, K_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                    K_ILLEGAL: bus.illegal_op = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (kind)
                    K_ALU: begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.alu_op = op_alu; bus.Zin = 1'b1; end
                    K_IMM: begin bus.Cout = 1'b1; bus.alu_op = op_alu; bus.Zin = 1'b1; end
                    K_UNARY: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    K_MULDIV: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.alu_op = op_alu; bus.Zin = 1'b1; end
                    K_LDI, K_LD, K_ST: begin bus.Cout = 1'b1; bus.alu_op = ALU_ADD; bus.Zin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (kind)
                    K_ALU, K_IMM, K_LDI: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    K_MULDIV: begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
                    K_LD, K_ST: begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (kind)
                    K_MULDIV: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
                    K_LD: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                    K_ST: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (kind)
                    K_LD: begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    K_ST: begin bus.MDRout = 1'b1; bus.Write = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-instruction micro-step list model
// predicts every cycle's control word; a monitor compares at each falling edge.
`timescale 1ns/1ps
module tb_control_unit;
    typedef logic [28:0] cw_t;

    localparam cw_t PCOUT   = cw_t'(1) << 0;
    localparam cw_t MARIN   = cw_t'(1) << 1;
    localparam cw_t INCPC   = cw_t'(1) << 2;
    localparam cw_t ZIN     = cw_t'(1) << 3;
    localparam cw_t ZLOWOUT = cw_t'(1) << 4;
    localparam cw_t ZHIOUT  = cw_t'(1) << 5;
    localparam cw_t PCIN    = cw_t'(1) << 6;
    localparam cw_t MDRIN   = cw_t'(1) << 7;
    localparam cw_t MDROUT  = cw_t'(1) << 8;
    localparam cw_t IRIN    = cw_t'(1) << 9;
    localparam cw_t YIN     = cw_t'(1) << 10;
    localparam cw_t HIIN    = cw_t'(1) << 11;
    localparam cw_t LOIN    = cw_t'(1) << 12;
    localparam cw_t COUT    = cw_t'(1) << 13;
    localparam cw_t GRA     = cw_t'(1) << 14;
    localparam cw_t GRB     = cw_t'(1) << 15;
    localparam cw_t GRC     = cw_t'(1) << 16;
    localparam cw_t RIN     = cw_t'(1) << 17;
    localparam cw_t ROUT    = cw_t'(1) << 18;
    localparam cw_t BAOUT   = cw_t'(1) << 19;
    localparam cw_t READ    = cw_t'(1) << 20;
    localparam cw_t WRITE   = cw_t'(1) << 21;
    localparam cw_t RUN     = cw_t'(1) << 26;
    localparam cw_t FAULT   = cw_t'(1) << 27;
    localparam cw_t ILL     = cw_t'(1) << 28;

    typedef struct { cw_t word; bit waits; } step_t;
    typedef enum { M_RST, M_RUN, M_HALT, M_FAULT } mode_t;

    logic clk = 1'b0;
    logic reset;
    control_unit_if bus();

    control_unit #(.MEM_TIMEOUT(15)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    cw_t dut_cw;
    assign dut_cw = {bus.illegal_op, bus.fault, bus.run, bus.alu_op, bus.Write, bus.Read,
                     bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.Cout,
                     bus.LOin, bus.HIin, bus.Yin, bus.IRin, bus.MDRout, bus.MDRin, bus.PCin,
                     bus.Zhighout, bus.Zlowout, bus.Zin, bus.IncPc, bus.MARin, bus.PCout};

    mode_t       mode = M_RST;
    step_t       steps[$];
    int          idx = 0;
    int          wcnt = 0;
    bit          fresh = 1'b0;
    bit          end_halt = 1'b0;
    logic [31:0] ir_next = 32'h0;
    cw_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic cw_t alu(input int code);
        return cw_t'(code) << 22;
    endfunction

    function automatic int alu_of(input logic [4:0] op);
        case (op)
            5'd3: return 0;  5'd4: return 1;  5'd5: return 8;  5'd6: return 9;
            5'd7: return 4;  5'd8: return 5;  5'd9: return 6;  5'd10: return 7;
            5'd11: return 0; 5'd12: return 8; 5'd13: return 9;
            5'd14: return 2; 5'd15: return 3; 5'd16: return 10; 5'd17: return 11;
            default: return 0;
        endcase
    endfunction

    task automatic add_step(input cw_t w, input bit wt);
        step_t s;
        s.word = w;
        s.waits = wt;
        steps.push_back(s);
    endtask

    // The whole instruction as an ordered list of micro-steps.
    task automatic build(input logic [31:0] ir_v);
        logic [4:0] op;
        cw_t a;
        op = ir_v[31:27];
        a = alu(alu_of(op));
        steps.delete();
        end_halt = 1'b0;
        add_step(PCOUT | MARIN | INCPC | ZIN, 1'b0);
        add_step(ZLOWOUT | PCIN | READ | MDRIN, 1'b1);
        add_step(MDROUT | IRIN, 1'b0);
        if (op >= 5'd3 && op <= 5'd10) begin
            add_step(GRB | ROUT | YIN, 1'b0);
            add_step(GRC | ROUT | a | ZIN, 1'b0);
            add_step(ZLOWOUT | GRA | RIN, 1'b0);
        end else if (op >= 5'd11 && op <= 5'd13) begin
            add_step(GRB | ROUT | YIN, 1'b0);
            add_step(COUT | a | ZIN, 1'b0);
            add_step(ZLOWOUT | GRA | RIN, 1'b0);
        end else if (op == 5'd16 || op == 5'd17) begin
            add_step(GRB | ROUT | a | ZIN, 1'b0);
            add_step(ZLOWOUT | GRA | RIN, 1'b0);
        end else if (op == 5'd14 || op == 5'd15) begin
            add_step(GRA | ROUT | YIN, 1'b0);
            add_step(GRB | ROUT | a | ZIN, 1'b0);
            add_step(ZLOWOUT | LOIN, 1'b0);
            add_step(ZHIOUT | HIIN, 1'b0);
        end else if (op <= 5'd2) begin
            add_step(GRB | BAOUT | YIN, 1'b0);
            add_step(COUT | ZIN, 1'b0);
            if (op == 5'd1) add_step(ZLOWOUT | GRA | RIN, 1'b0);
            else            add_step(ZLOWOUT | MARIN, 1'b0);
            if (op == 5'd0) begin
                add_step(READ | MDRIN, 1'b1);
                add_step(MDROUT | GRA | RIN, 1'b0);
            end else if (op == 5'd2) begin
                add_step(GRA | ROUT | MDRIN, 1'b0);
                add_step(MDROUT | WRITE, 1'b1);
            end
        end else if (op == 5'd24) begin
            // nop: fetch only
        end else if (op == 5'd25) begin
            end_halt = 1'b1;
        end else begin
            add_step(ILL, 1'b0);
        end
    endtask

    task automatic enter_t0(input bit stop_v);
        if (stop_v) mode = M_HALT;
        else begin
            mode = M_RUN; fresh = 1'b1; idx = 0; wcnt = 0;
        end
    endtask

    // One clock: drive inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input bit rst_v, input bit ack_v, input bit stop_v);
        cw_t e;
        @(posedge clk); #1;
        cyc++;
        if (mode == M_RUN && fresh) begin
            bus.ir = ir_next;
            build(ir_next);
            fresh = 1'b0;
        end
        reset = rst_v; bus.mem_ack = ack_v; bus.stop = stop_v;
        case (mode)
            M_RUN:   e = steps[idx].word | RUN;
            M_FAULT: e = FAULT;
            default: e = '0;
        endcase
        exp_q.push_back(e);
        if (!rst_v) begin
            mode = M_RST; wcnt = 0;
        end else begin
            case (mode)
                M_RST: enter_t0(stop_v);
                M_RUN: begin
                    if (steps[idx].waits && !ack_v) begin
                        if (wcnt == 15) mode = M_FAULT;
                        else wcnt++;
                    end else begin
                        wcnt = 0;
                        idx++;
                        if (idx == steps.size()) begin
                            if (end_halt) mode = M_HALT;
                            else enter_t0(stop_v);
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'($urandom), 1'b0);
        step(1'b0, 1'($urandom), 1'b0);
    endtask

    // Run one instruction; stall = ack-low cycles per memory wait,
    // stop held from step stop_from, reset pulsed at step rst_at (-1 = never).
    task automatic do_instr(input logic [31:0] ir_v, input int stall,
                            input int stop_from, input int rst_at);
        int n;
        bit st, rs, ak, rst_done;
        n = 0;
        rst_done = 1'b0;
        if (mode == M_HALT || mode == M_FAULT) do_reset();
        ir_next = ir_v;
        while (mode == M_RST) step(1'b1, 1'b1, 1'b0);
        do begin
            st = (stop_from >= 0) && (idx >= stop_from);
            rs = !(idx == rst_at && !rst_done && !fresh);
            if (!rs) rst_done = 1'b1;
            if (fresh || !steps[idx].waits) ak = 1'($urandom);
            else ak = (wcnt >= stall);
            step(rs, ak, st);
            n++;
        end while (mode == M_RUN && !fresh && n < 100);
        if (n >= 100) check("instr_bound", n, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check($sformatf("cyc%0d", cyc), dut_cw, exp_q.pop_front());
    end

    initial begin
        logic [4:0] op;
        int stall, stop_from, rst_at;
        reset = 1'b0; bus.ir = 32'h0; bus.mem_ack = 1'b0; bus.stop = 1'b0;

        do_reset();
        do_instr(32'h1800_0000, 0, -1, -1);   // add
        do_instr(32'h0080_0005, 3, -1, -1);   // ld with stalls
        do_instr(32'h1080_0005, 0, -1, -1);   // st
        do_instr(32'h7000_0000, 0, -1, -1);   // mul
        do_instr(32'h7800_0000, 0, -1, -1);   // div
        do_instr(32'h1800_0000, 15, -1, -1);  // ack on the timeout cycle wins
        do_instr(32'h1800_0000, 16, -1, -1);  // T1 timeout -> FAULT
        repeat (3) step(1'b1, 1'b1, 1'b0);
        do_instr(32'hA000_0000, 0, -1, -1);   // illegal opcode
        do_instr(32'hC800_0000, 0, -1, -1);   // halt
        repeat (3) step(1'b1, 1'b1, 1'b0);
        do_instr(32'h1800_0000, 0, 4, -1);    // stop from add T4
        do_instr(32'h0080_0005, 0, -1, 6);    // reset at ld T6
        do_reset();
        step(1'b1, 1'b1, 1'b1);               // stop on leaving RST
        step(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 7) op = 5'($urandom_range(0, 17));
            else op = 5'($urandom_range(18, 31));
            stall = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) stall = 16;
            else if ($urandom_range(0, 19) == 0) stall = 15;
            stop_from = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 7) : -1;
            rst_at    = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 7) : -1;
            do_instr({op, 27'($urandom)}, stall, stop_from, rst_at);
        end

        @(posedge clk); @(posedge clk);
        check("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
